// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants for the encoder, sign-extension unit and decoder.
// Also holds the signed 12-bit immediate range check used by the I, L and S formats.
package instr_encoder_pkg;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;

    // True when imm sign-extends losslessly from bit 11 (-2048..2047).
    function automatic logic imm_fits12(input logic [31:0] imm);
        return imm[31:11] == {21{imm[11]}};
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
// The head reads as zero while empty, so out_data is defined after reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW:0]      wr_ptr;
    logic [IW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (IW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields (I, L, S, R formats) into instruction words and
// queues them with sequential byte addresses for loading instruction memory.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    opcode,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [7:0]    err_count
);

    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (opcode)
            OP_I, OP_L: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = imm_fits12(imm);
            end
            OP_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = imm_fits12(imm);
            end
            OP_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (pop)
                out_addr <= out_addr + AW'(4);
            // Illegal fields still complete the handshake; only the error state records them.
            if (accept && !legal) begin
                err <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
